// File: rtl/core_run_controller_pkg.sv
// -----------------------------------------------------------------------------
// core_run_controller_pkg
// Shared definitions for the run controller: FSM state encodings and the
// default halt instruction encoding (jal x0,0 self-loop).
// -----------------------------------------------------------------------------
package core_run_controller_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_006F;

endpackage

// File: rtl/core_run_controller_cycle_counter.sv
// -----------------------------------------------------------------------------
// core_run_controller_cycle_counter
// Counts RUN cycles for the run controller and flags the watchdog terminal
// value (count == MAX_CYCLES-1, i.e. the last permitted RUN cycle).
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_clear     synchronous clear (new run requested)
//   i_enable    increment this cycle
//   o_count     cycles counted so far
//   o_terminal  count has reached MAX_CYCLES-1
// -----------------------------------------------------------------------------
module core_run_controller_cycle_counter #(
    parameter int unsigned MAX_CYCLES = 10000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_enable,
    output logic [31:0] o_count,
    output logic        o_terminal
);

    logic [31:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 32'd0;
        end else if (i_clear) begin
            r_count <= 32'd0;
        end else if (i_enable) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == 32'(MAX_CYCLES - 1));

endmodule

// File: rtl/core_run_controller.sv
// -----------------------------------------------------------------------------
// core_run_controller
// Sequences a single-cycle core for one program run: holds the core in reset,
// streams a program image into instruction memory, releases the core and
// counts cycles, and stops on a halt instruction or watchdog timeout.
// Ports:
//   i_clk, i_rst_n         clock / asynchronous active-low reset
//   i_start                one-cycle request to begin load+run (IDLE/DONE only)
//   i_load_valid/o_load_ready/i_load_data/i_load_last   program image stream
//   o_imem_we/o_imem_addr/o_imem_wdata                  imem write port
//   o_core_rst             active-low core reset (high only while running)
//   i_core_instr, i_core_pc   core fetch observation
//   o_busy                 LOAD or RUN
//   o_done, o_timeout      run finished / finished by watchdog
//   o_cycle_count          RUN cycles elapsed
//   o_halt_pc              PC at halt or timeout
// -----------------------------------------------------------------------------
module core_run_controller
    import core_run_controller_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          MAX_CYCLES = 10000,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = DATA_WIDTH'(HALT_INSTR_DEFAULT)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_load_valid,
    output logic                  o_load_ready,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    input  logic                  i_load_last,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [DATA_WIDTH-1:0] o_imem_wdata,
    output logic                  o_core_rst,
    input  logic [DATA_WIDTH-1:0] i_core_instr,
    input  logic [31:0]           i_core_pc,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [31:0]           o_cycle_count,
    output logic [31:0]           o_halt_pc
);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_core_rst;
    logic                  r_done;
    logic                  r_timeout;
    logic [31:0]           r_halt_pc;

    logic w_clear;
    logic w_accept;
    logic w_last_accept;
    logic w_running;
    logic w_halt;
    logic w_terminal;
    logic w_stop;

    assign w_running     = (r_state == ST_RUN);
    assign w_clear       = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_start;
    assign w_accept      = (r_state == ST_LOAD) && i_load_valid;
    // Image ends on load_last or when the last imem word has been written.
    assign w_last_accept = w_accept && (i_load_last || (r_addr == '1));
    assign w_halt        = w_running && (i_core_instr == HALT_INSTR);
    assign w_stop        = w_running && (w_halt || w_terminal);

    core_run_controller_cycle_counter #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_cycle_counter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (w_clear),
        .i_enable   (w_running),
        .o_count    (o_cycle_count),
        .o_terminal (w_terminal)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (i_start)       w_next_state = ST_LOAD;
            ST_LOAD:          if (w_last_accept) w_next_state = ST_RUN;
            ST_RUN:           if (w_stop)        w_next_state = ST_DONE;
            default:                             w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_core_rst <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_halt_pc  <= 32'd0;
        end else begin
            r_state <= w_next_state;
            // Registered so the core leaves reset exactly on the first RUN cycle.
            r_core_rst <= (w_next_state == ST_RUN);
            if (w_clear) begin
                r_addr    <= '0;
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
                r_halt_pc <= 32'd0;
            end else if (w_accept) begin
                r_addr <= w_last_accept ? '0 : r_addr + ADDR_WIDTH'(1);
            end else if (w_stop) begin
                r_halt_pc <= i_core_pc;
                r_done    <= 1'b1;
                // Halt wins over a coincident watchdog expiry.
                r_timeout <= !w_halt;
            end
        end
    end

    assign o_load_ready = (r_state == ST_LOAD);
    assign o_imem_we    = w_accept;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = i_load_data;
    assign o_core_rst   = r_core_rst;
    assign o_busy       = (r_state == ST_LOAD) || w_running;
    assign o_done       = r_done;
    assign o_timeout    = r_timeout;
    assign o_halt_pc    = r_halt_pc;

endmodule
